// File: rtl/uart_rx_byte_receiver.sv
// UART 8N1 receiver: 16x oversampled serial line into a one-entry byte buffer.
// Latency: Empty falls one cycle after the stop-bit mid sample (~9.5 bit times + 2 sync cycles after start edge).
// Backpressure: consumer drains with Unload_data; a byte completing while the buffer is full is dropped and flags Overrun.
module uart_rx_byte_receiver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Unload_data,
  input  logic       UART_RX_I,
  output logic [7:0] RX_data,
  output logic       Empty,
  output logic       Overrun,
  output logic       Frame_error
);

  localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW       = $clog2(TICK_DIV);
  localparam int SW       = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            empty_q, empty_d;
  logic            overrun_q, overrun_d;
  logic            frame_error_q, frame_error_d;

  // Decodes shared by next-state and output logic
  logic rx_fall, tick, bit_end, mid_tick, stop_sample, unload, byte_ok, byte_bad;

  assign rx_fall  = rx_prev_q & ~rx_s_q;
  assign tick     = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
  assign bit_end  = tick && (sample_cnt_q == SAMPLE_LAST);
  assign mid_tick = tick && (sample_cnt_q == SAMPLE_MID);

  // State register
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start-bit qualification at mid bit, 8 data bits, one stop bit
  always_comb begin
    state_d = state_q;
    if (!Enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (rx_fall) state_d = S_START;
        S_START: if (mid_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
        S_DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = S_STOP;
        S_STOP:  if (bit_end) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs/datapath: counters, shift register, byte buffer and sticky flags
  always_comb begin
    tick_cnt_d    = '0;
    sample_cnt_d  = sample_cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    empty_d       = empty_q;
    overrun_d     = overrun_q;
    frame_error_d = frame_error_q;

    stop_sample = Enable && (state_q == S_STOP) && bit_end;
    byte_ok     = stop_sample && rx_s_q;
    byte_bad    = stop_sample && !rx_s_q;
    unload      = Unload_data && !empty_q;

    // Tick divider free-runs while a frame is in progress; idle keeps it at zero
    if (state_q != S_IDLE) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        sample_cnt_d = '0;
        bit_idx_d    = '0;
      end
      S_START: begin
        if (mid_tick) begin
          sample_cnt_d = '0;
          bit_idx_d    = '0;
        end else if (tick) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sample_cnt_d = '0;
          shreg_d      = {rx_s_q, shreg_q[7:1]};
          bit_idx_d    = (bit_idx_q == 3'd7) ? 3'd0 : bit_idx_q + 1'b1;
        end else if (tick) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          sample_cnt_d = '0;
        end else if (tick) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
      default: sample_cnt_d = '0;
    endcase

    // Buffer: an unload in the same cycle frees the slot for the arriving byte
    if (unload) begin
      empty_d = 1'b1;
    end
    if (byte_ok) begin
      if (empty_q || unload) begin
        rx_data_d = shreg_q;
        empty_d   = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (byte_bad) begin
      frame_error_d = 1'b1;
    end

    // Disable abandons any partial frame and clears buffer state; RX_data is kept
    if (!Enable) begin
      tick_cnt_d    = '0;
      sample_cnt_d  = '0;
      bit_idx_d     = '0;
      empty_d       = 1'b1;
      overrun_d     = 1'b0;
      frame_error_d = 1'b0;
    end
  end

  // Synchroniser, edge history and datapath registers
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      tick_cnt_q    <= '0;
      sample_cnt_q  <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      empty_q       <= 1'b1;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_meta_q     <= UART_RX_I;
      rx_s_q        <= rx_meta_q;
      rx_prev_q     <= rx_s_q;
      tick_cnt_q    <= tick_cnt_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      empty_q       <= empty_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign RX_data     = rx_data_q;
  assign Empty       = empty_q;
  assign Overrun     = overrun_q;
  assign Frame_error = frame_error_q;

endmodule
